// File: rtl/neural_pkg.sv
// neural_pkg: constants and the FSM state type shared by the shift arbiter.
package neural_pkg;
    localparam int DATA_W_DEFAULT = 32;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/shift_arb_pick.sv
// shift_arb_pick: one-hot picker searching from ptr+1 upward, wrapping modulo N_REQ.
module shift_arb_pick #(
    parameter int N_REQ = 4,
    parameter int PW = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PW-1:0]    idx
);
    logic [PW-1:0] j;
    always_comb begin
        grant = '0;
        idx = '0;
        j = '0;
        // Descending offsets so the nearest candidate after ptr is the one left standing.
        for (int i = N_REQ; i >= 1; i--) begin
            j = PW'((int'(ptr) + i) % N_REQ);
            if (valid[j]) begin
                grant = '0;
                grant[j] = 1'b1;
                idx = j;
            end
        end
    end
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: shares one shifter unit among N_REQ requesters.
// Define SHIFT_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module shift_arbiter
    import neural_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int SHIFT_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_base,
    input  logic [N_REQ*DATA_W-1:0] req_power,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_result,
    output logic [DATA_W-1:0]       sh_base,
    output logic [DATA_W-1:0]       sh_power,
    input  logic [DATA_W-1:0]       sh_result,
    output logic                    busy
);
    localparam int PW = $clog2(N_REQ);

    state_t state, nxt;
    logic [CNT_W-1:0] cnt;
    logic [PW-1:0] g, ptr, pick_idx;
    logic [N_REQ-1:0] pick;
    logic accept;
    logic [DATA_W-1:0] base_arr [N_REQ];
    logic [DATA_W-1:0] power_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign base_arr[i] = req_base[i*DATA_W +: DATA_W];
        assign power_arr[i] = req_power[i*DATA_W +: DATA_W];
    end

`ifdef SHIFT_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= PW'(N_REQ - 1);
        else if (accept) ptr <= pick_idx;
    end
`else
    // A pointer pinned at the top index makes the rotating search start at 0.
    assign ptr = PW'(N_REQ - 1);
`endif

    shift_arb_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .valid(req_valid),
        .ptr(ptr),
        .grant(pick),
        .idx(pick_idx)
    );

    assign req_ready = (state == IDLE && !rst) ? pick : '0;
    assign accept = |(req_valid & req_ready);
    assign rsp_valid = (state == RESP) ? N_REQ'(1) << g : '0;
    assign busy = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        nxt = (state == IDLE) ? (accept ? WAIT : IDLE) :
              (state == WAIT) ? (cnt == '0 ? RESP : WAIT) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            g <= '0;
            sh_base <= '0;
            sh_power <= '0;
            rsp_result <= '0;
        end else if (accept) begin
            cnt <= CNT_W'(SHIFT_LAT);
            g <= pick_idx;
            sh_base <= base_arr[pick_idx];
            sh_power <= power_arr[pick_idx];
        end else if (state == WAIT) begin
            cnt <= (cnt == '0) ? cnt : cnt - 1'b1;
            if (cnt == '0) rsp_result <= sh_result;
        end
    end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed stimulus with a timeline model of the arbiter and a shifter model.
module tb_shift_arbiter;
    localparam int N = 4;
    localparam int W = 32;
    localparam int LAT = 1;

    logic clk = 0;
    logic rst = 0;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready, rsp_valid;
    logic [N*W-1:0] req_base = '0;
    logic [N*W-1:0] req_power = '0;
    logic [W-1:0] rsp_result, sh_base, sh_power;
    logic [W-1:0] sh_result = '0;
    logic busy;

    int total = 0;
    int bad = 0;

    // Model: m_t = cycles since accept (-1 when idle)
    int m_t = -1;
    int m_g = 0;
    int m_ptr = N - 1;
    logic [W-1:0] m_base = '0, m_pow = '0, m_res = '0;

    always #5 clk = ~clk;

    shift_arbiter #(.N_REQ(N), .DATA_W(W), .SHIFT_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_base(req_base), .req_power(req_power),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .sh_base(sh_base), .sh_power(sh_power), .sh_result(sh_result),
        .busy(busy)
    );

    always @(posedge clk) sh_result <= sh_base << sh_power;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int pick_m();
        for (int i = 1; i <= N; i++) begin
            int j;
`ifdef SHIFT_ARB_RR_EN
            j = (m_ptr + i) % N;
`else
            j = i - 1;
`endif
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [W-1:0] b, input logic [W-1:0] p);
        req_base[i*W +: W] = b;
        req_power[i*W +: W] = p;
        req_valid[i] = 1'b1;
    endtask

    // Compare at negedge against the model, advance the model to the next edge.
    task automatic cycle();
        int p;
        @(negedge clk);
        if (rst) begin
            m_t = -1; m_ptr = N - 1; m_base = '0; m_pow = '0; m_res = '0;
        end
        p = pick_m();
        chk("m_ready", req_ready, (m_t < 0 && p >= 0 && !rst) ? 64'(1 << p) : 64'd0);
        chk("m_busy", busy, m_t >= 0);
        chk("m_sh_base", sh_base, m_base);
        chk("m_sh_power", sh_power, m_pow);
        chk("m_rsp_valid", rsp_valid, (m_t == LAT + 1) ? 64'(1 << m_g) : 64'd0);
        chk("m_rsp_result", rsp_result, m_res);
        if (!rst) begin
            if (m_t < 0) begin
                if (p >= 0) begin
                    m_t = 0; m_g = p; m_ptr = p;
                    m_base = req_base[p*W +: W];
                    m_pow = req_power[p*W +: W];
                end
            end else begin
                m_t++;
                if (m_t == LAT + 1) m_res = m_base << m_pow;
                else if (m_t > LAT + 1) m_t = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g_q[$];
        int at_q[$];
        logic [W-1:0] r_q[$];
        #1 rst = 1;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_sh_base", sh_base, 0);
        chk("rst_sh_power", sh_power, 0);
        chk("rst_busy", busy, 0);
        cycle(); cycle();
        rst = 0;

        // Single request from 0: 2 << 2
        set_req(0, 2, 2);
        #1 chk("t1_ready", req_ready, 4'b0001);
        cycle();
        req_valid = '0;
        #1;
        chk("t1_sh_base", sh_base, 2);
        chk("t1_sh_power", sh_power, 2);
        chk("t1_busy", busy, 1);
        cycle(); cycle();
        chk("t1_rsp_valid", rsp_valid, 4'b0001);
        chk("t1_rsp_result", rsp_result, 8);
        cycle();
        chk("t1_idle_rsp", rsp_valid, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_hold", rsp_result, 8);

        // Single request from 1: 10 << 1
        set_req(1, 10, 1);
        #1 chk("t2_ready", req_ready, 4'b0010);
        cycle();
        req_valid = '0;
        cycle();
        chk("t2_busy_wait", busy, 1);
        cycle();
        chk("t2_rsp_valid", rsp_valid, 4'b0010);
        chk("t2_rsp_result", rsp_result, 20);
        chk("t2_busy_resp", busy, 1);
        cycle();
        chk("t2_busy_idle", busy, 0);

        rst = 1;
        cycle();
        rst = 0;

        // Contention: base 1, power i
        for (int i = 0; i < N; i++) set_req(i, 1, i);
        for (int c = 0; c < 16; c++) begin
            #1;
            if (req_ready != 0) begin
                g_q.push_back($clog2(req_ready));
                at_q.push_back(c);
            end
            if (rsp_valid != 0) r_q.push_back(rsp_result);
            cycle();
        end
        req_valid = '0;
        chk("cont_grants", g_q.size(), 4);
        chk("cont_results", r_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < g_q.size()) begin
`ifdef SHIFT_ARB_RR_EN
                chk("cont_grant", g_q[k], k);
`else
                chk("cont_grant", g_q[k], 0);
`endif
            end
            if (k < r_q.size()) begin
`ifdef SHIFT_ARB_RR_EN
                chk("cont_result", r_q[k], 1 << k);
`else
                chk("cont_result", r_q[k], 1);
`endif
            end
            if (k > 0 && k < at_q.size()) chk("cont_spacing", at_q[k] - at_q[k-1], LAT + 3);
        end

        // Late arrival of requester 2 during WAIT
        set_req(0, 5, 3);
        #1;
        cycle();
        req_valid = '0;
        set_req(2, 7, 1);
        #1 chk("late_wait_ready", req_ready, 0);
        cycle();
        chk("late_wait2_ready", req_ready, 0);
        cycle();
        chk("late_resp_ready", req_ready, 0);
        chk("late_resp_valid", rsp_valid, 4'b0001);
        chk("late_resp_result", rsp_result, 40);
        cycle();
        chk("late_idle_ready", req_ready, 4'b0100);
        cycle();
        req_valid = '0;
        repeat (3) cycle();

        // Reset during WAIT
        req_valid = '1;
        #1;
        cycle();
        rst = 1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_sh_base", sh_base, 0);
        chk("mid_rst_sh_power", sh_power, 0);
        chk("mid_rst_result", rsp_result, 0);
        cycle(); cycle();
        rst = 0;
        #1 chk("post_rst_grant", req_ready, 4'b0001);
        cycle();
        req_valid = '0;
        repeat (3) cycle();

        // Power beyond DATA_W passes through untouched
        set_req(3, 3, 40);
        #1;
        cycle();
        req_valid = '0;
        #1;
        chk("pt_sh_base", sh_base, 3);
        chk("pt_sh_power", sh_power, 40);
        cycle(); cycle();
        chk("pt_rsp_valid", rsp_valid, 4'b1000);
        chk("pt_rsp_result", rsp_result, 0);
        cycle(); cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Controller that shares one `Shifter` datapath instance between `N_REQ` neuron-side requesters. It accepts one request at a time over a valid/ready handshake and drives the shared unit's `base` and `power` inputs. After a fixed latency it captures the shared unit's `result` and returns it to the granted requester as a one-cycle response pulse. It sits between the neuron array and the single shift/exponent unit.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters; range 2..8.
- `DATA_W`, default 32: operand and result width.
- `SHIFT_LAT`, default 1: clock edges from a stable `sh_base`/`sh_power` to a valid `sh_result`; range 1..15.

Ports:
- `clk`  in  1  single clock; rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  one-hot accept; combinational.
- `req_base`  in  N_REQ*DATA_W  packed operands; requester i occupies slice i.
- `req_power`  in  N_REQ*DATA_W  packed operands; requester i occupies slice i.
- `rsp_valid`  out  N_REQ  one-hot, one-cycle response pulse.
- `rsp_result`  out  DATA_W  shared response bus.
- `sh_base`  out  DATA_W  to the shared unit; registered.
- `sh_power`  out  DATA_W  to the shared unit; registered.
- `sh_result`  in  DATA_W  from the shared unit.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any `req_valid` is high, the arbiter picks grant `g` and drives `req_ready = 1<<g`. Otherwise `req_ready = 0`.
  - On the edge where `req_valid[g] & req_ready[g]` is true, the block latches slice g of `req_base`/`req_power` into `sh_base`/`sh_power` and records `g`.
  - On the same edge it loads `cnt = SHIFT_LAT` and moves to WAIT.
- WAIT:
  - `req_ready = 0`; `sh_base`/`sh_power` are held.
  - `cnt` decrements each edge.
  - On the edge where `cnt == 0`, the block registers `rsp_result <= sh_result` and moves to RESP.
- RESP: `rsp_valid = 1<<g` for exactly this cycle; the next edge moves to IDLE.
- `req_ready` is asserted only in IDLE, so requests that arrive during WAIT or RESP wait until IDLE.
- Operands pass through unchanged. No clamping of `power` ≥ `DATA_W`; those semantics belong to the shared unit.
- A requester that drops `req_valid` before acceptance is simply not granted.
- Reset during WAIT or RESP aborts the operation: no `rsp_valid` is produced and the FSM returns to IDLE.
- Reset values: state IDLE, `req_ready` 0, `rsp_valid` 0, `rsp_result` 0, `sh_base` 0, `sh_power` 0, `busy` 0, `cnt` 0, RR pointer `N_REQ-1`.

## Timing
- Accept at edge k, with `sh_*` valid from k. `rsp_result` is captured at edge k+SHIFT_LAT+1, and `rsp_valid` is high between edges k+SHIFT_LAT+1 and k+SHIFT_LAT+2.
- The earliest next accept is edge k+SHIFT_LAT+3, giving a throughput of one op per SHIFT_LAT+3 cycles.
- `rsp_result` holds its value until the next capture.

## Configuration
- `SHIFT_ARB_RR_EN` defined: round-robin arbitration.
  - Search starts at `last_grant+1` and wraps modulo `N_REQ`.
  - The pointer updates only on accept.
  - After reset, requester 0 has highest priority.
- Undefined: fixed priority, lowest index wins. The pointer register is absent.

## Structure
- Shared package `neural_pkg`:
  - `DATA_W` default constant.
  - FSM state typedef (`IDLE`, `WAIT`, `RESP`).
  - Max-latency counter width (4 bits).
- One sub-module, `shift_arb_pick`: combinational one-hot picker taking `req_valid`, the pointer, and the macro-selected policy.
- The top level holds the FSM, the counter and the operand/result registers.

## Test plan
Behavioural shifter model: `result = base << power`, `SHIFT_LAT=1`, `N_REQ=4`.
- Single request: `req_valid[0]`, base=2, power=2. Expect `req_ready[0]` on the accept cycle, `sh_base`=2 and `sh_power`=2, then `rsp_valid[0]` for one cycle two edges after accept with `rsp_result`=8.
- Single request: requester 1, base=10, power=1. Expect `rsp_valid[1]` only and `rsp_result`=20; `busy` stays high from accept until the RESP→IDLE edge.
- Contention: all four requesters hold valid with base=1 and power=i.
  - With `SHIFT_ARB_RR_EN`: grants 0,1,2,3 and results 1,2,4,8, with 4-cycle accept spacing.
  - Without the macro: requester 0 wins every accept while valid.
- Late arrival: `req_valid[2]` rises during WAIT of requester 0's op. Expect `req_ready[2]` only after RESP, in the following IDLE cycle.
- Reset mid-op: assert `rst` during WAIT. Expect all outputs 0 immediately and no `rsp_valid`; after release, with all requesters valid, grant 0 first.
- Operand pass-through: power=40 (≥`DATA_W`), base=3. Expect `sh_power`=40 unmodified and `rsp_result` equal to the model's `sh_result`.
